nvram_hps_sync: RTL

- Sequencer sitting directly upstream of the 8 KB CD-i NVRAM/timekeeper on its HPS backup/restore port.
- Bridges the MiSTer hps_io SD-block interface to that port.
- On image mount, restores 16 × 512-byte sectors into NVRAM. On OSD request or autosave timeout, writes NVRAM back to the image.
- Gates CPU access while a transfer is in flight.

---
 rtl/nvram_hps_sync.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/nvram_hps_sync.sv
// Bridges the hps_io SD-block interface to the CD-i NVRAM backup/restore port:
// restores the image on mount, writes it back on OSD request or autosave timeout.
module nvram_hps_sync #(
    parameter int unsigned AUTOSAVE_CYCLES = 60_000_000,
    parameter int unsigned SECTORS         = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        img_mounted,
    input  logic        img_readonly,
    input  logic [63:0] img_size,
    input  logic        save_request,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    input  logic [7:0]  sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,
    output logic [12:0] nvram_backup_restore_adr,
    output logic [7:0]  nvram_restore_data,
    output logic        nvram_restore_write,
    input  logic [7:0]  nvram_backup_data,
    input  logic        nvram_cpu_changed,
    output logic        nvram_allow_cpu_access,
    output logic        busy,
    output logic        dirty
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_XFER = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_WR_XFER = 3'd4;

    localparam int unsigned CW = (AUTOSAVE_CYCLES > 1) ? $clog2(AUTOSAVE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX     = CW'(AUTOSAVE_CYCLES);
    localparam logic [CW-1:0] CNT_EXP     = CW'(AUTOSAVE_CYCLES - 1);
    localparam logic [3:0]    LAST_SECTOR = 4'(SECTORS - 1);
    localparam logic [63:0]   NVRAM_BYTES = 64'd8192;

    logic [2:0]    state_q, state_d;
    logic [3:0]    sector_q, sector_d;
    logic          sd_rd_q, sd_rd_d;
    logic          sd_wr_q, sd_wr_d;
    logic          dirty_q, dirty_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mount_pend_q, mount_pend_d;
    logic          sd_ack_q;

    logic          mounted_q, mounted_d;
    logic          ro_q, ro_d;
    logic [63:0]   size_q, size_d;

    logic          mount_evt;
    logic [63:0]   eff_size;
    logic          ack_fall;
    logic          expire;
    logic          save_trig;

    always_comb begin
        mounted_d = img_mounted ? (img_size != 64'd0) : mounted_q;
        ro_d      = img_mounted ? img_readonly : ro_q;
        size_d    = img_mounted ? img_size : size_q;

        // A mount that aborted a transfer is replayed from IDLE using the latched size.
        mount_evt = img_mounted | mount_pend_q;
        eff_size  = img_mounted ? img_size : size_q;
        ack_fall  = sd_ack_q & ~sd_ack;
        expire    = (AUTOSAVE_CYCLES != 0) && (state_q == S_IDLE) && (cnt_q == CNT_EXP);
        save_trig = (save_request | expire) & mounted_q & ~ro_q & dirty_q;

        state_d      = state_q;
        sector_d     = sector_q;
        sd_rd_d      = sd_rd_q;
        sd_wr_d      = sd_wr_q;
        dirty_d      = dirty_q;
        mount_pend_d = mount_pend_q;

        case (state_q)
            S_IDLE: begin
                if (mount_evt) begin
                    mount_pend_d = 1'b0;
                    if (eff_size >= NVRAM_BYTES) begin
                        state_d  = S_RD_REQ;
                        sector_d = '0;
                        sd_rd_d  = 1'b1;
                    end else if (eff_size != 64'd0) begin
                        dirty_d = 1'b1;
                    end
                end else if (save_trig) begin
                    state_d  = S_WR_REQ;
                    sector_d = '0;
                    sd_wr_d  = 1'b1;
                    dirty_d  = 1'b0;
                end
            end
            S_RD_REQ: begin
                if (sd_ack) begin
                    sd_rd_d = 1'b0;
                    state_d = S_RD_XFER;
                end
            end
            S_RD_XFER: begin
                if (ack_fall) begin
                    sector_d = sector_q + 4'd1;
                    if (sector_q == LAST_SECTOR) begin
                        state_d = S_IDLE;
                        dirty_d = 1'b0;
                    end else begin
                        state_d = S_RD_REQ;
                        sd_rd_d = 1'b1;
                    end
                end
            end
            S_WR_REQ: begin
                if (sd_ack) begin
                    sd_wr_d = 1'b0;
                    state_d = S_WR_XFER;
                end
            end
            S_WR_XFER: begin
                if (ack_fall) begin
                    sector_d = sector_q + 4'd1;
                    if (sector_q == LAST_SECTOR) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WR_REQ;
                        sd_wr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                sd_rd_d = 1'b0;
                sd_wr_d = 1'b0;
            end
        endcase

        if (img_mounted && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            sector_d     = '0;
            sd_rd_d      = 1'b0;
            sd_wr_d      = 1'b0;
            mount_pend_d = 1'b1;
        end

        // CPU writes re-mark dirty even over a clear issued in the same cycle.
        if (nvram_cpu_changed) begin
            dirty_d = 1'b1;
        end

        cnt_d = cnt_q;
        if (nvram_cpu_changed || !dirty_q) begin
            cnt_d = '0;
        end else if ((state_q == S_IDLE) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sector_q     <= '0;
            sd_rd_q      <= 1'b0;
            sd_wr_q      <= 1'b0;
            dirty_q      <= 1'b0;
            cnt_q        <= '0;
            mount_pend_q <= 1'b0;
            sd_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sector_q     <= sector_d;
            sd_rd_q      <= sd_rd_d;
            sd_wr_q      <= sd_wr_d;
            dirty_q      <= dirty_d;
            cnt_q        <= cnt_d;
            mount_pend_q <= mount_pend_d;
            sd_ack_q     <= sd_ack;
        end
    end

    // Image descriptors mirror HPS state and survive core reset.
    always_ff @(posedge clk) begin
        mounted_q <= mounted_d;
        ro_q      <= ro_d;
        size_q    <= size_d;
    end

    always_comb begin
        sd_lba                   = {28'd0, sector_q};
        sd_rd                    = sd_rd_q;
        sd_wr                    = sd_wr_q;
        sd_buff_din              = nvram_backup_data;
        nvram_restore_write      = (state_q == S_RD_XFER) && sd_buff_wr;
        nvram_restore_data       = (state_q == S_RD_XFER) ? sd_buff_dout : '0;
        nvram_backup_restore_adr = ((state_q == S_RD_XFER) || (state_q == S_WR_XFER))
                                   ? {sector_q, sd_buff_addr} : '0;
        nvram_allow_cpu_access   = (state_q == S_IDLE);
        busy                     = (state_q != S_IDLE);
        dirty                    = dirty_q;
    end

endmodule
